obstacle_spawner: RTL and testbench
===================================

# obstacle_spawner

Consumer side of the `lfsr16` random-number interface. The block sits between the game-state controller and the obstacle sprite engine. It pulls one random word per obstacle: it asserts `next_o` to the LFSR and reads `rand_i`. From that word it derives an obstacle kind and a spawn gap in frames. It counts frame ticks and emits a one-cycle spawn pulse when the gap expires.

## Interface
- `MinGap`, default 40: minimum frames between spawns; must be ≥1.
- `GapBits`, default 6: number of random bits added to `MinGap`, giving a random range of 0..2^GapBits−1.
- `clk_i`  in  1: the single clock.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `run_i`  in  1: game running (level); low forces idle.
- `tick_i`  in  1: one-cycle frame strobe.
- `rand_i`  in  16: current LFSR word; connect to `lfsr16.rand_o`.
- `next_o`  out  1: one-cycle request to advance the LFSR; connect to `lfsr16.next_i`.
- `spawn_o`  out  1: one-cycle pulse; an obstacle enters the screen.
- `kind_o`  out  2: kind of the pending/just-spawned obstacle (`obstacle_kind_e`).
- `busy_o`  out  1: high when state ≠ IDLE.

## Operation
- Kind mapping from `rand_i[1:0]`: 0 = CACTUS_S, 1 = CACTUS_M, 2 = CACTUS_L, 3 = BIRD.
- Gap = `MinGap + rand_i[GapBits+1:2]`, zero-extended to counter width `$clog2(MinGap + 2**GapBits)`. No overflow is possible at this width.
- State machine:
  - **IDLE**: all outputs 0 except `kind_o`, which holds its last value. `run_i`=1 → DRAW.
  - **DRAW**: exactly 1 cycle. Assert `next_o`=1. In the same cycle, sample `rand_i` into `kind_q` and load the counter with the gap. → WAIT.
  - **WAIT**: on `tick_i`, if counter==1 → SPAWN, else decrement. Cycles without a tick hold the counter.
  - **SPAWN**: exactly 1 cycle, `spawn_o`=1. → DRAW if `run_i`, else IDLE.
- `run_i`=0 in any state → IDLE on the next edge. The counter clears and no `spawn_o` or `next_o` is issued in that transition.
- `tick_i` is ignored in IDLE, DRAW and SPAWN; it is not queued.
- `kind_o` = `kind_q`. It updates one cycle after DRAW and stays stable through WAIT and SPAWN.

## Timing
- Reset values: state IDLE, `next_o`=0, `spawn_o`=0, `busy_o`=0, `kind_o`=0, counter 0.
- `run_i` rising in cycle N: DRAW in N+1 (`next_o` high), WAIT from N+2.
- Spawn occurs on the edge after the gap-th `tick_i` counted in WAIT. `spawn_o` is high the following cycle.
- `rand_i` is sampled in the same cycle `next_o` is high. This is the pre-advance word; the LFSR advances on that edge, so every draw uses a fresh word.
- Exactly one `next_o` pulse per obstacle. `next_o` and `spawn_o` are never high in the same cycle.
- `run_i` falling in the same cycle as the final tick: `run_i` wins, no spawn.
- Reset asserted mid-WAIT: asynchronous return to reset values. After release, a new DRAW follows once `run_i` is high.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Structure
- Shared package `dino_pkg`: `obstacle_kind_e` (2-bit enum above), `spawner_state_e` (IDLE/DRAW/WAIT/SPAWN), and a `RandWidth`=16 constant.
- One sub-module is natural: `tick_countdown`, a loadable down-counter with a tick enable and an `at_one_o` flag, parameterised by width.
- The `lfsr16` instance is external. Bench and top level both connect it directly.

## Test plan
- Reset, then `run_i`=1, connected to `lfsr16` (seed 0x0001). The first draw reads 0x0001, giving kind CACTUS_M and gap 40. `spawn_o` pulses after exactly the 40th tick, with 1 `next_o` seen.
- Continue running. The second draw reads 0x0002, giving CACTUS_L and gap 40. The third reads 0x0004, giving CACTUS_S and gap 41. Check both `spawn_o` times and both `kind_o` values.
- Irregular ticks: insert 0–5 idle cycles between ticks. Spawn is still on the 40th tick, and the counter holds between ticks.
- Drop `run_i` with the counter at 1, in the same cycle as a tick. Required: no `spawn_o`, IDLE next cycle, `busy_o`=0, and no extra `next_o`.
- Assert `rst_ni` asynchronously mid-WAIT, between clock edges. Outputs clear immediately. After release with `run_i`=1, the first `next_o` comes 1 cycle later.
- Force `rand_i`=0xFFFF (stub). Required: kind BIRD and gap 40+63=103, so the spawn lands on tick 103 with no counter overflow.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared types for the dino game blocks: obstacle kinds, spawner FSM states and
// the random-word width.
package dino_pkg;

   localparam int unsigned RandWidth = 16;

   typedef enum logic [1:0] {
      KindCactusS = 2'd0,
      KindCactusM = 2'd1,
      KindCactusL = 2'd2,
      KindBird    = 2'd3
   } obstacle_kind_e;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDraw  = 2'd1,
      StWait  = 2'd2,
      StSpawn = 2'd3
   } spawner_state_e;

endpackage

// File: rtl/tick_countdown.sv
// Loadable down-counter advanced by a tick enable. It stops at 1, and at_one_o is
// decoded from the count register.
module tick_countdown #(
   parameter int unsigned Width = 7
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             tick_i,
   output logic             at_one_o
);

   localparam logic [Width-1:0] One = Width'(1);

   logic [Width-1:0] r_count;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_count <= '0;
      end else if (clr_i) begin
         r_count <= '0;
      end else if (load_i) begin
         r_count <= load_val_i;
      end else if (tick_i && (r_count > One)) begin
         r_count <= r_count - One;
      end
   end

   assign at_one_o = (r_count == One);

endmodule

// File: rtl/obstacle_spawner.sv
// Draws one LFSR word per obstacle and turns it into a kind and a spawn gap in frames.
// After that many frame ticks it pulses spawn_o.
module obstacle_spawner
   import dino_pkg::*;
#(
   parameter int unsigned MinGap  = 40,
   parameter int unsigned GapBits = 6
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 run_i,
   input  logic                 tick_i,
   input  logic [RandWidth-1:0] rand_i,
   output logic                 next_o,
   output logic                 spawn_o,
   output obstacle_kind_e       kind_o,
   output logic                 busy_o
);

   localparam int unsigned CntW = $clog2(MinGap + 2 ** GapBits);

   spawner_state_e r_state;
   spawner_state_e w_state_next;
   obstacle_kind_e r_kind;
   logic [CntW-1:0] w_gap;
   logic            w_at_one;
   logic            w_clr;
   logic            w_load;
   logic            w_dec;
   logic            w_unused_rand;

   // The counter is wide enough for MinGap + (2^GapBits - 1), so this sum never wraps.
   assign w_gap         = CntW'(MinGap) + CntW'(rand_i[GapBits+1:2]);
   assign w_unused_rand = ^rand_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // DRAW always consumes the word, because next_o advances the LFSR in that cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_kind <= KindCactusS;
      end else if (r_state == StDraw) begin
         r_kind <= obstacle_kind_e'(rand_i[1:0]);
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  w_state_next = StDraw;
         StDraw:  w_state_next = StWait;
         StWait:  if (tick_i && w_at_one) w_state_next = StSpawn;
         StSpawn: w_state_next = StDraw;
         default: w_state_next = StIdle;
      endcase
      if (!run_i) begin
         w_state_next = StIdle;
      end
   end

   assign w_clr  = !run_i;
   assign w_load = (r_state == StDraw);
   assign w_dec  = (r_state == StWait) && tick_i;

   tick_countdown #(
      .Width (CntW)
   ) u_countdown (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clr_i      (w_clr),
      .load_i     (w_load),
      .load_val_i (w_gap),
      .tick_i     (w_dec),
      .at_one_o   (w_at_one)
   );

   assign next_o  = (r_state == StDraw);
   assign spawn_o = (r_state == StSpawn);
   assign busy_o  = (r_state != StIdle);
   assign kind_o  = r_kind;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed-plus-random bench for obstacle_spawner, driven by a behavioural LFSR or a
// constant stub word.
module tb_obstacle_spawner;
   import dino_pkg::*;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           run;
   logic           tick;
   logic           use_stub;
   logic [15:0]    lfsr_q;
   logic [15:0]    rand_w;
   logic           next;
   logic           spawn;
   logic           busy;
   obstacle_kind_e kind;

   int n_cmp   = 0;
   int n_err   = 0;
   int n_next  = 0;
   int n_spawn = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_step(input logic [15:0] w);
      return {w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]};
   endfunction

   // External lfsr16 stand-in, seeded with 0x0001 and advanced on each request.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= 16'h0001;
      else if (next) lfsr_q <= lfsr_step(lfsr_q);
   end

   assign rand_w = use_stub ? 16'hFFFF : lfsr_q;

   always @(posedge clk) begin
      if (next) n_next <= n_next + 1;
      if (spawn) n_spawn <= n_spawn + 1;
   end

   obstacle_spawner #(
      .MinGap  (40),
      .GapBits (6)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .run_i   (run),
      .tick_i  (tick),
      .rand_i  (rand_w),
      .next_o  (next),
      .spawn_o (spawn),
      .kind_o  (kind),
      .busy_o  (busy)
   );

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered with the DUT in DRAW. The kind and gap come straight from the word's
   // field arithmetic. If abort is set, run drops together with the final tick.
   task automatic obstacle(input logic [15:0] w, input int max_idle, input bit abort,
                           input string tag);
      int kind_exp;
      int gap;
      int n0;
      int idle;
      kind_exp = int'(w) % 4;
      gap      = 40 + (int'(w) / 4) % 64;
      n0       = n_next;
      chk({tag, " next in draw"}, 32'(next), 1);
      step;
      chk({tag, " kind"}, 32'(kind), kind_exp);
      chk({tag, " next after draw"}, 32'(next), 0);
      chk({tag, " busy in wait"}, 32'(busy), 1);
      for (int t = 1; t <= gap; t++) begin
         idle = $urandom_range(max_idle, 0);
         repeat (idle) begin
            step;
            chk({tag, " no spawn between ticks"}, 32'(spawn), 0);
         end
         tick = 1'b1;
         if (abort && t == gap) run = 1'b0;
         step;
         tick = 1'b0;
         if (abort && t == gap) begin
            chk({tag, " no spawn on abort"}, 32'(spawn), 0);
            chk({tag, " idle after abort"}, 32'(busy), 0);
            chk({tag, " no next on abort"}, 32'(next), 0);
         end else begin
            chk({tag, " spawn at tick"}, 32'(spawn), 32'(t == gap));
         end
      end
      chk({tag, " kind stable"}, 32'(kind), kind_exp);
      chk({tag, " one next per obstacle"}, n_next - n0, 1);
   endtask

   initial begin
      rst_n    = 1'b0;
      run      = 1'b0;
      tick     = 1'b0;
      use_stub = 1'b0;
      repeat (3) step;
      chk("reset next", 32'(next), 0);
      chk("reset spawn", 32'(spawn), 0);
      chk("reset busy", 32'(busy), 0);
      chk("reset kind", 32'(kind), 0);

      rst_n = 1'b1;
      step;
      chk("idle while run low", 32'(busy), 0);

      run = 1'b1;
      step;
      obstacle(16'h0001, 0, 1'b0, "o1");
      step;
      chk("spawn is one cycle", 32'(spawn), 0);
      obstacle(16'h0002, 5, 1'b0, "o2");
      step;
      obstacle(16'h0004, 2, 1'b0, "o3");
      step;
      obstacle(16'h0008, 1, 1'b0 | 1'b1, "abort");
      step;
      chk("abort stays idle", 32'(busy), 0);
      chk("abort no late next", 32'(next), 0);
      chk("abort no spawn counted", n_spawn, 3);

      // Async reset in the middle of a WAIT, landing between clock edges.
      use_stub = 1'b1;
      run      = 1'b1;
      step;
      step;
      chk("stub kind before reset", 32'(kind), 3);
      tick = 1'b1;
      repeat (5) step;
      tick = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async reset busy", 32'(busy), 0);
      chk("async reset next", 32'(next), 0);
      chk("async reset spawn", 32'(spawn), 0);
      chk("async reset kind", 32'(kind), 0);
      step;
      rst_n = 1'b1;
      step;
      chk("next one cycle after release", 32'(next), 1);
      obstacle(16'hFFFF, 1, 1'b0, "stub");
      step;
      run = 1'b0;
      step;
      chk("idle after run low", 32'(busy), 0);
      chk("kind holds in idle", 32'(kind), 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
